// File: rtl/alarm_mode_ctrl_if.sv
// Button, tick and match inputs plus mode/indicator outputs of the alarm
// mode controller, bundled between the button front end and the datapath.
interface alarm_mode_ctrl_if;
   logic       C;
   logic       L;
   logic       R;
   logic       U;
   logic       D;
   logic       tick1Hz;
   logic       match;
   logic       run_en;
   logic [1:0] adj_sel;
   logic       adj_up;
   logic       adj_dn;
   logic       show_alarm;
   logic       LD0;
   logic       LD12;
   logic       LD13;
   logic       LD14;
   logic       LD15;
   logic       buzzer;
   logic       dp1;

   modport master (
      output C, L, R, U, D, tick1Hz, match,
      input  run_en, adj_sel, adj_up, adj_dn, show_alarm,
      input  LD0, LD12, LD13, LD14, LD15, buzzer, dp1
   );

   modport slave (
      input  C, L, R, U, D, tick1Hz, match,
      output run_en, adj_sel, adj_up, adj_dn, show_alarm,
      output LD0, LD12, LD13, LD14, LD15, buzzer, dp1
   );
endinterface

// File: rtl/alarm_mode_ctrl.sv
// Alarm clock mode sequencer, adjust strobe generator and ring scheduler.
// Optional snooze state is enabled with `define ALARM_SNOOZE_EN.
module alarm_mode_ctrl #(
   parameter int HOLD_CYC   = 100,
   parameter int RPT_CYC    = 20,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300
) (
   input logic clkBTN,
   input logic rst,
   alarm_mode_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_CLK  = 3'd0,
      S_TH   = 3'd1,
      S_TM   = 3'd2,
      S_AH   = 3'd3,
      S_AM   = 3'd4,
      S_RING = 3'd5
`ifdef ALARM_SNOOZE_EN
      , S_SNOOZE = 3'd6
`endif
   } state_t;

   localparam logic [15:0] HOLD     = 16'(HOLD_CYC);
   localparam logic [15:0] RPT_BASE = 16'(HOLD_CYC - RPT_CYC);
   localparam logic [7:0]  RING_MAX = 8'(RING_SEC);
   // Auto-repeat stays off for parameter sets where it makes no sense.
   localparam bit CFG_OK = (HOLD_CYC > RPT_CYC) && (RPT_CYC > 0)
                        && (RING_SEC > 0) && (SNOOZE_SEC > 0);

   logic        c_q, l_q, r_q, u_q, d_q, m_q;
   logic        pc, pl, pr, pu, pd;
   state_t      state, nxt;
   logic [15:0] hold_cnt, hold_nxt;
   logic [7:0]  ring_cnt;
   logic        blink, blink_n;
   logic        up_n, dn_n, fire;
   logic        rise, edit, edit_n, any_p;
   logic        ring_in, ring_n, snz_n;

`ifdef ALARM_SNOOZE_EN
   localparam logic [8:0] SNZ_MAX = 9'(SNOOZE_SEC);
   logic [8:0] snz_cnt;
`endif

   always_comb begin
      rise  = bus.match & ~m_q;
      any_p = pc | pl | pr | pu | pd;
      edit  = state inside {S_TH, S_TM, S_AH, S_AM};
      nxt   = state;
      case (state)
         S_CLK:
            if (pc)        nxt = S_TH;
            else if (rise) nxt = S_RING;
         S_TH:
            if (pc)        nxt = S_CLK;
            else if (pr)   nxt = S_TM;
            else if (pl)   nxt = S_AM;
         S_TM:
            if (pc)        nxt = S_CLK;
            else if (pr)   nxt = S_AH;
            else if (pl)   nxt = S_TH;
         S_AH:
            if (pc)        nxt = S_CLK;
            else if (pr)   nxt = S_AM;
            else if (pl)   nxt = S_TM;
         S_AM:
            if (pc)        nxt = S_CLK;
            else if (pr)   nxt = S_TH;
            else if (pl)   nxt = S_AH;
`ifdef ALARM_SNOOZE_EN
         S_RING:
            if (pc | pl | pr | pd)     nxt = S_CLK;
            else if (pu)               nxt = S_SNOOZE;
            else if (ring_cnt >= RING_MAX) nxt = S_CLK;
         S_SNOOZE:
            if (pc | pl | pr | pd)     nxt = S_CLK;
            else if (snz_cnt >= SNZ_MAX) nxt = S_RING;
`else
         S_RING:
            if (any_p || ring_cnt >= RING_MAX) nxt = S_CLK;
`endif
         default: nxt = S_CLK;
      endcase
   end

   // Hold counter reloads after each repeat so it never overflows.
   always_comb begin
      hold_nxt = '0;
      fire     = 1'b0;
      up_n     = 1'b0;
      dn_n     = 1'b0;
      if (edit && nxt == state && (u_q ^ d_q)) begin
         hold_nxt = hold_cnt + 16'd1;
         if (CFG_OK && hold_nxt == HOLD) begin
            hold_nxt = RPT_BASE;
            fire     = 1'b1;
         end
         up_n = (pu & ~d_q) | (fire & u_q);
         dn_n = (pd & ~u_q) | (fire & d_q);
      end
   end

   always_comb begin
      edit_n  = nxt inside {S_TH, S_TM, S_AH, S_AM};
      ring_n  = (nxt == S_RING);
      ring_in = ring_n && (state != S_RING);
`ifdef ALARM_SNOOZE_EN
      snz_n   = (nxt == S_SNOOZE);
`else
      snz_n   = 1'b0;
`endif
      blink_n = 1'b0;
      if (ring_in)     blink_n = 1'b1;
      else if (ring_n) blink_n = bus.tick1Hz ? ~blink : blink;
   end

   always_ff @(posedge clkBTN or posedge rst) begin
      if (rst) begin
         c_q            <= 1'b0;
         l_q            <= 1'b0;
         r_q            <= 1'b0;
         u_q            <= 1'b0;
         d_q            <= 1'b0;
         m_q            <= 1'b0;
         pc             <= 1'b0;
         pl             <= 1'b0;
         pr             <= 1'b0;
         pu             <= 1'b0;
         pd             <= 1'b0;
         state          <= S_CLK;
         hold_cnt       <= '0;
         ring_cnt       <= '0;
         blink          <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt        <= '0;
`endif
         bus.run_en     <= 1'b1;
         bus.dp1        <= 1'b1;
         bus.adj_sel    <= 2'd0;
         bus.adj_up     <= 1'b0;
         bus.adj_dn     <= 1'b0;
         bus.show_alarm <= 1'b0;
         bus.LD0        <= 1'b0;
         bus.LD12       <= 1'b0;
         bus.LD13       <= 1'b0;
         bus.LD14       <= 1'b0;
         bus.LD15       <= 1'b0;
         bus.buzzer     <= 1'b0;
      end else begin
         c_q <= bus.C;
         l_q <= bus.L;
         r_q <= bus.R;
         u_q <= bus.U;
         d_q <= bus.D;
         m_q <= bus.match;
         pc  <= bus.C & ~c_q;
         pl  <= bus.L & ~l_q;
         pr  <= bus.R & ~r_q;
         pu  <= bus.U & ~u_q;
         pd  <= bus.D & ~d_q;

         state    <= nxt;
         hold_cnt <= hold_nxt;
         blink    <= blink_n;

         if (ring_in)
            ring_cnt <= '0;
         else if (state == S_RING && bus.tick1Hz && ring_cnt != 8'hFF)
            ring_cnt <= ring_cnt + 8'd1;

`ifdef ALARM_SNOOZE_EN
         if (snz_n && state != S_SNOOZE)
            snz_cnt <= '0;
         else if (state == S_SNOOZE && bus.tick1Hz && snz_cnt != 9'h1FF)
            snz_cnt <= snz_cnt + 9'd1;
`endif

         bus.run_en     <= ~edit_n;
         bus.dp1        <= ~edit_n;
         bus.adj_up     <= up_n;
         bus.adj_dn     <= dn_n;
         bus.show_alarm <= (nxt == S_AH) || (nxt == S_AM);
         bus.LD0        <= edit_n | (ring_n & blink_n) | snz_n;
         bus.LD12       <= (nxt == S_TH);
         bus.LD13       <= (nxt == S_TM);
         bus.LD14       <= (nxt == S_AH);
         bus.LD15       <= (nxt == S_AM);
         bus.buzzer     <= ring_n & blink_n;
         case (nxt)
            S_TM:    bus.adj_sel <= 2'd1;
            S_AH:    bus.adj_sel <= 2'd2;
            S_AM:    bus.adj_sel <= 2'd3;
            default: bus.adj_sel <= 2'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Directed bench for alarm_mode_ctrl: edit ring, auto-repeat,
// alarm ring/timeout, and snooze when ALARM_SNOOZE_EN is defined.
module tb_alarm_mode_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   alarm_mode_ctrl_if bus ();

   alarm_mode_ctrl dut (
      .clkBTN (clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // {run_en,dp1,LD0,LD12,LD13,LD14,LD15,buzzer,show_alarm,adj_sel,up,dn}
   localparam logic [12:0] V_CLK  = 13'b1100000000000;
   localparam logic [12:0] V_TH   = 13'b0011000000000;
   localparam logic [12:0] V_TM   = 13'b0010100000100;
   localparam logic [12:0] V_AH   = 13'b0010010011000;
   localparam logic [12:0] V_AM   = 13'b0010001011100;
   localparam logic [12:0] V_RNG1 = 13'b1110000100000;
   localparam logic [12:0] V_SNZ  = 13'b1110000000000;
   localparam logic [12:0] V_DN   = 13'b0000000000001;

   logic [12:0] vec;
   assign vec = {bus.run_en, bus.dp1, bus.LD0, bus.LD12, bus.LD13,
                 bus.LD14, bus.LD15, bus.buzzer, bus.show_alarm,
                 bus.adj_sel, bus.adj_up, bus.adj_dn};

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns after the edge that applies the press to the state.
   task automatic press(input logic c, input logic l, input logic r,
                        input logic u, input logic d);
      bus.C = c; bus.L = l; bus.R = r; bus.U = u; bus.D = d;
      @(negedge clk);
      bus.C = 0; bus.L = 0; bus.R = 0; bus.U = 0; bus.D = 0;
      @(negedge clk);
   endtask

   task automatic tick2();
      bus.tick1Hz = 1'b1;
      @(negedge clk);
      bus.tick1Hz = 1'b0;
      @(negedge clk);
   endtask

   int          n_up;
   int          n_dn;
   logic [4:0]  pos;
   logic [59:0] bz_obs;
   logic [59:0] bz_exp;

   initial begin
      bus.C = 0; bus.L = 0; bus.R = 0; bus.U = 0; bus.D = 0;
      bus.tick1Hz = 0; bus.match = 0;
      cyc(3);
      chk("reset", 64'(vec), 64'(V_CLK));
      rst = 1'b0;
      cyc(2);

      press(1, 0, 0, 0, 0); chk("C->TH", 64'(vec), 64'(V_TH));
      press(0, 0, 1, 0, 0); chk("R->TM", 64'(vec), 64'(V_TM));
      press(0, 0, 1, 0, 0); chk("R->AH", 64'(vec), 64'(V_AH));
      press(0, 0, 1, 0, 0); chk("R->AM", 64'(vec), 64'(V_AM));
      press(0, 0, 1, 0, 0); chk("R->TH", 64'(vec), 64'(V_TH));
      press(0, 1, 0, 0, 0); chk("L->AM", 64'(vec), 64'(V_AM));
      press(0, 1, 0, 0, 0); chk("L->AH", 64'(vec), 64'(V_AH));
      press(0, 1, 0, 0, 0); chk("L->TM", 64'(vec), 64'(V_TM));
      cyc(2);

      // Hold U for 160 sampled edges; pulses at hold cycles 1,100,120,140,160
      n_up = 0; n_dn = 0; pos = '0;
      bus.U = 1'b1;
      for (int i = 1; i <= 170; i++) begin
         @(negedge clk);
         if (i == 160) bus.U = 1'b0;
         n_up += int'(bus.adj_up);
         n_dn += int'(bus.adj_dn);
         if (i == 2)   pos[4] = bus.adj_up;
         if (i == 101) pos[3] = bus.adj_up;
         if (i == 121) pos[2] = bus.adj_up;
         if (i == 141) pos[1] = bus.adj_up;
         if (i == 161) pos[0] = bus.adj_up;
      end
      chk("rpt_up_count", 64'(n_up), 64'd5);
      chk("rpt_up_pos", 64'(pos), 64'h1F);
      chk("rpt_dn_quiet", 64'(n_dn), 64'd0);
      chk("rpt_state", 64'(vec), 64'(V_TM));

      press(0, 0, 0, 0, 1);
      chk("D_pulse", 64'(vec), 64'(V_TM | V_DN));
      cyc(1);
      chk("D_single", 64'(vec), 64'(V_TM));

      n_up = 0; n_dn = 0;
      bus.U = 1'b1; bus.D = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_up += int'(bus.adj_up);
         n_dn += int'(bus.adj_dn);
      end
      bus.U = 1'b0; bus.D = 1'b0;
      cyc(3);
      chk("UD_none", 64'(n_up + n_dn), 64'd0);

      press(1, 0, 0, 0, 0); chk("C->CLK", 64'(vec), 64'(V_CLK));
      press(1, 0, 0, 0, 0); chk("C->TH2", 64'(vec), 64'(V_TH));
      press(1, 1, 1, 0, 0); chk("CRL->CLK", 64'(vec), 64'(V_CLK));
      cyc(2);

      // Alarm ring with full timeout
      bus.match = 1'b1;
      @(negedge clk);
      chk("ring_enter", 64'(vec), 64'(V_RNG1));
      bz_obs = '0; bz_exp = '0;
      for (int k = 1; k <= 59; k++) begin
         bus.tick1Hz = 1'b1;
         @(negedge clk);
         bz_obs[k] = bus.buzzer;
         bz_exp[k] = (k % 2) == 0;
         bus.tick1Hz = 1'b0;
         @(negedge clk);
      end
      chk("ring_blink", 64'(bz_obs), 64'(bz_exp));
      bus.tick1Hz = 1'b1;
      @(negedge clk);
      chk("ring_tick60", 64'(vec), 64'(V_RNG1));
      bus.tick1Hz = 1'b0;
      @(negedge clk);
      chk("ring_timeout", 64'(vec), 64'(V_CLK));
      cyc(10);
      chk("no_rering", 64'(vec), 64'(V_CLK));
      bus.match = 1'b0;
      cyc(2);

      bus.match = 1'b1;
      @(negedge clk);
      chk("ring2_enter", 64'(vec), 64'(V_RNG1));
      press(0, 0, 0, 0, 1);
      chk("ring_D_stop", 64'(vec), 64'(V_CLK));
      bus.match = 1'b0;
      cyc(2);

      bus.match = 1'b1;
      @(negedge clk);
      chk("ring3_enter", 64'(vec), 64'(V_RNG1));
      rst = 1'b1;
      #1;
      chk("rst_mid_ring", 64'(vec), 64'(V_CLK));
      bus.match = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc(2);

      press(1, 0, 0, 0, 0);
      bus.U = 1'b1;
      cyc(110);
      rst = 1'b1;
      #1;
      chk("rst_mid_rpt", 64'(vec), 64'(V_CLK));
      bus.U = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc(2);

`ifdef ALARM_SNOOZE_EN
      bus.match = 1'b1;
      @(negedge clk);
      chk("snz_ring", 64'(vec), 64'(V_RNG1));
      press(0, 0, 0, 1, 0);
      chk("U->SNOOZE", 64'(vec), 64'(V_SNZ));
      for (int k = 1; k <= 299; k++) tick2();
      chk("snz_299", 64'(vec), 64'(V_SNZ));
      bus.tick1Hz = 1'b1;
      @(negedge clk);
      chk("snz_300", 64'(vec), 64'(V_SNZ));
      bus.tick1Hz = 1'b0;
      @(negedge clk);
      chk("snz->RING", 64'(vec), 64'(V_RNG1));
      press(0, 0, 0, 1, 0);
      chk("U->SNOOZE2", 64'(vec), 64'(V_SNZ));
      cyc(5);
      rst = 1'b1;
      #1;
      chk("rst_mid_snz", 64'(vec), 64'(V_CLK));
      bus.match = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc(2);
`else
      bus.match = 1'b1;
      @(negedge clk);
      chk("ringU_enter", 64'(vec), 64'(V_RNG1));
      press(0, 0, 0, 1, 0);
      chk("ring_U_stop", 64'(vec), 64'(V_CLK));
      bus.match = 1'b0;
      cyc(2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alarm_mode_ctrl.md
# alarm_mode_ctrl

Mode sequencer and alarm scheduler for the alarm clock. It sits between the debounced push-buttons and the time/alarm counter datapath, all clocked on clkBTN. It decides which field is being edited and turns U/D presses into single-cycle adjust pulses, with auto-repeat while a button is held. It also gates the running clock and drives the alarm ring sequence, the LEDs, the buzzer and the decimal point.

## Interface
Parameters:
- HOLD_CYC, default 100: clkBTN cycles U/D must stay held before auto-repeat starts.
- RPT_CYC, default 20: clkBTN cycles between auto-repeat pulses.
- RING_SEC, default 60: maximum ring duration, counted in tick1Hz pulses.
- SNOOZE_SEC, default 300: snooze delay, counted in tick1Hz pulses. Used only with ALARM_SNOOZE_EN.

Ports:
- clkBTN, input, 1: block clock.
- rst, input, 1: reset, asynchronous, active-high.
- C, L, R, U, D, inputs, 1 each: debounced button levels, synchronous to clkBTN.
- tick1Hz, input, 1: one-clkBTN-cycle pulse once per second.
- match, input, 1: level, high when time count equals alarm count.
- run_en, output, 1: enables the free-running time counters.
- adj_sel, output, 2: field being edited. 0 = time hour, 1 = time minute, 2 = alarm hour, 3 = alarm minute.
- adj_up, adj_dn, outputs, 1 each: one-cycle increment/decrement strobes for the field selected by adj_sel.
- show_alarm, output, 1: display mux select; 1 shows the alarm count.
- LD0, LD12, LD13, LD14, LD15, buzzer, dp1, outputs, 1 each: indicators.

## Operation
- Each of C/L/R/U/D is registered once; a press is level high while the registered copy is low.
- States are CLK, TH, TM, AH, AM, RING, plus SNOOZE when configured. The 3-bit state register resets to CLK.
- Presses of C, R and L in the same cycle resolve as C > R > L; only one transition happens.
- CLK:
  - C press -> TH.
  - A rising edge of match (match high, registered match low) with no C press -> RING.
- TH, TM, AH, AM:
  - C press -> CLK.
  - R press -> next state in the ring TH -> TM -> AH -> AM -> TH.
  - L press -> previous state in that ring.
- RING:
  - Any press of C/L/R/U/D -> CLK.
  - Ring counter reaching RING_SEC -> CLK.
- Outputs decode the state register:
  - CLK: run_en=1, dp1=1, all LEDs=0, buzzer=0.
  - Edit states: run_en=0, dp1=0, LD0=1. Exactly one of LD12..LD15 is high (TH, TM, AH, AM respectively), and adj_sel follows that order.
  - show_alarm=1 in AH and AM only.
  - RING: run_en=1, dp1=1, LD0=buzzer=blink.
- blink:
  - Set to 1 on RING entry.
  - Toggles on each tick1Hz while in RING.
  - Cleared outside RING.
- Adjust strobes, edit states only:
  - adj_up pulses on a U press; adj_dn pulses on a D press.
  - U and D both high: no pulse, and the hold counter clears.
  - While exactly one of U/D stays high, a 16-bit hold counter counts cycles. A further pulse is issued when it reaches HOLD_CYC, then every RPT_CYC cycles after that.
  - Releasing the button or changing state clears the counter.
- adj_up and adj_dn are never high together and never high outside edit states.
- The ring counter is 8 bits and saturating. It clears on RING entry and increments on tick1Hz in RING.
- The controller performs no BCD or 24-hour wrap arithmetic; that stays in the datapath.

## Timing
- Reset values:
  - state=CLK, run_en=1, dp1=1.
  - adj_up=adj_dn=0, adj_sel=0, show_alarm=0.
  - All LEDs=0, buzzer=0, blink=0.
  - All counters=0 and all button/match registers=0.
- A button level first sampled high at edge N:
  - The state changes at edge N+1.
  - adj_up/adj_dn is high for exactly the cycle after edge N+1.
- LED, run_en, dp1, show_alarm and adj_sel change in the same cycle as the state.
- The ring times out on the RING_SEC-th tick1Hz after entry; the state is CLK on the following edge.
- If match is already high on return to CLK, there is no re-ring; ringing needs a fresh rising edge.
- rst asserted mid-ring or mid-repeat takes effect immediately: state CLK and outputs at reset values.

## Configuration
- ALARM_SNOOZE_EN defined:
  - In RING, a U press -> SNOOZE. All other presses and the timeout still -> CLK.
  - SNOOZE: run_en=1, dp1=1, LD0=1 steady, buzzer=0. It counts tick1Hz up to SNOOZE_SEC (9-bit counter), then -> RING with the ring counter cleared.
  - Any press of C/L/R/D in SNOOZE -> CLK.
- ALARM_SNOOZE_EN undefined:
  - The SNOOZE state and its counter are absent.
  - U in RING behaves like any other button and goes to CLK.

## Test plan
- Reset, then C, R, R, R, R, L (one press each): states TH, TM, AH, AM, TH, AM; LD12..15 one-hot matches; show_alarm=1 only in AH/AM.
- In TM, hold U for 160 cycles with HOLD_CYC=100, RPT_CYC=20: adj_up pulses at hold cycles 1, 100, 120, 140, 160 (5 pulses); adj_dn stays 0.
- In CLK, raise match: RING one cycle after detection, buzzer toggles per tick1Hz; after 60 ticks -> CLK with match still high and no re-ring.
- In RING, press D: CLK next cycle, buzzer=0. Pressing C, R and L together in TH -> CLK.
- With ALARM_SNOOZE_EN: U in RING -> SNOOZE; after 300 ticks -> RING. Assert rst mid-SNOOZE: state CLK, all outputs at reset values immediately.
